// File: rtl/sprite_regctl_pkg.sv
// Shared constants for the sprite register controller: register map, CTRL bits,
// bus access encodings and the commit sequencer state type.
package sprite_regctl_pkg;

  localparam int NUM_SHADOW = 6;

  localparam logic [3:0] WORD_CTRL      = 4'd0;
  localparam logic [3:0] WORD_SPR0_XY   = 4'd1;
  localparam logic [3:0] WORD_SPR0_BMP0 = 4'd2;
  localparam logic [3:0] WORD_SPR0_BMP1 = 4'd3;
  localparam logic [3:0] WORD_SPR1_XY   = 4'd4;
  localparam logic [3:0] WORD_SPR1_BMP0 = 4'd5;
  localparam logic [3:0] WORD_SPR1_BMP1 = 4'd6;
  localparam logic [3:0] WORD_FRAME     = 4'd7;

  localparam int CTRL_SPRITE_EN = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_IRQ_FLAG  = 2;
  localparam int CTRL_COMMIT    = 3;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;
  localparam logic [1:0] ACC_NONE = 2'b11;

  // Only x[9:0] and y[25:16] exist in the XY words.
  localparam logic [31:0] XY_MASK = 32'h03FF_03FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COPY  = 2'd2
  } commit_state_e;

  function automatic logic is_xy_word(input logic [3:0] word);
    return (word == WORD_SPR0_XY) || (word == WORD_SPR1_XY);
  endfunction

endpackage

// File: rtl/sprite_regctl_lane_merge.sv
// Byte-lane merge of a bus write into an existing 32-bit word
// (8-bit -> lane 0, 16-bit -> lanes 0-1, 32-bit -> all lanes).
module sprite_regctl_lane_merge
  import sprite_regctl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (data_write_n)
      ACC_BYTE: new_word[7:0]  = data_in[7:0];
      ACC_HALF: new_word[15:0] = data_in[15:0];
      ACC_WORD: new_word       = data_in;
      default:  new_word       = old_word;
    endcase
  end

endmodule

// File: rtl/tqvp_sprite_regctl.sv
// Sprite register controller: shadow bank, vblank-synchronised commit into the live bank,
// VSYNC interrupt flag and frame counter. Define SPRITE_REGCTL_READBACK_EN for shadow readback.
module tqvp_sprite_regctl #(
  parameter int NUM_SHADOW = sprite_regctl_pkg::NUM_SHADOW,
  parameter int FRAME_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   address,
  input  logic [31:0]  data_in,
  input  logic [1:0]   data_write_n,
  input  logic [1:0]   data_read_n,
  output logic [31:0]  data_out,
  output logic         data_ready,
  input  logic         vblank_start,
  output logic         sprite_en,
  output logic [9:0]   spr0_x,
  output logic [9:0]   spr0_y,
  output logic [9:0]   spr1_x,
  output logic [9:0]   spr1_y,
  output logic [63:0]  spr0_bmp,
  output logic [63:0]  spr1_bmp,
  output logic         user_interrupt
);
  import sprite_regctl_pkg::*;

  localparam int IDX_W = $clog2(NUM_SHADOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHADOW - 1);

  logic [31:0] shadow_q [NUM_SHADOW];
  logic [31:0] shadow_d [NUM_SHADOW];
  logic [31:0] live_q   [NUM_SHADOW];
  logic [31:0] live_d   [NUM_SHADOW];

  commit_state_e state_q, state_d;
  logic [IDX_W-1:0] copy_idx_q, copy_idx_d;
  logic re_arm_q, re_arm_d;
  logic sprite_en_q, sprite_en_d;
  logic irq_en_q, irq_en_d;
  logic irq_flag_q, irq_flag_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic [3:0]       word;
  logic [IDX_W-1:0] sh_idx;
  logic             wr_req, rd_req, is_shadow, copying, wr_stall;
  logic             ctrl_wr, shadow_wr, commit_wr;
  logic [31:0]      merge_old, merge_new, rd_word;

  assign word      = address[5:2];
  assign sh_idx    = IDX_W'(word - WORD_SPR0_XY);
  assign wr_req    = (data_write_n != ACC_NONE);
  assign rd_req    = (data_read_n != ACC_NONE);
  assign is_shadow = (word >= WORD_SPR0_XY) && (word <= WORD_SPR1_BMP1);
  assign copying   = (state_q == ST_COPY);
  // Shadow writes are held off while the sequencer is reading the shadow bank.
  assign wr_stall  = wr_req && is_shadow && copying;
  assign ctrl_wr   = wr_req && (word == WORD_CTRL);
  assign shadow_wr = wr_req && is_shadow && !copying;
  assign commit_wr = ctrl_wr && data_in[CTRL_COMMIT];

  assign merge_old = is_shadow ? shadow_q[sh_idx] : '0;

  sprite_regctl_lane_merge u_lane_merge (
    .old_word     (merge_old),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .new_word     (merge_new)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (shadow_wr) begin
      shadow_d[sh_idx] = is_xy_word(word) ? (merge_new & XY_MASK) : merge_new;
    end
  end

  always_comb begin
    live_d = live_q;
    if (copying) begin
      live_d[copy_idx_q] = shadow_q[copy_idx_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    copy_idx_d = copy_idx_q;
    re_arm_d   = re_arm_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_wr) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (vblank_start) begin
          state_d    = ST_COPY;
          copy_idx_d = '0;
        end
      end
      ST_COPY: begin
        copy_idx_d = copy_idx_q + 1'b1;
        if (commit_wr) re_arm_d = 1'b1;
        if (copy_idx_q == LAST_IDX) begin
          state_d    = (re_arm_q || commit_wr) ? ST_ARMED : ST_IDLE;
          copy_idx_d = '0;
          re_arm_d   = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        copy_idx_d = '0;
        re_arm_d   = 1'b0;
      end
    endcase
  end

  // A vblank set is applied after the write-1-clear so the set wins a same-cycle collision.
  always_comb begin
    sprite_en_d = sprite_en_q;
    irq_en_d    = irq_en_q;
    irq_flag_d  = irq_flag_q;
    frame_d     = frame_q;
    if (ctrl_wr) begin
      sprite_en_d = data_in[CTRL_SPRITE_EN];
      irq_en_d    = data_in[CTRL_IRQ_EN];
      if (data_in[CTRL_IRQ_FLAG]) irq_flag_d = 1'b0;
    end
    if (vblank_start) begin
      frame_d = frame_q + 1'b1;
      if (irq_en_q) irq_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHADOW; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      state_q     <= ST_IDLE;
      copy_idx_q  <= '0;
      re_arm_q    <= 1'b0;
      sprite_en_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_flag_q  <= 1'b0;
      frame_q     <= '0;
    end else begin
      shadow_q    <= shadow_d;
      live_q      <= live_d;
      state_q     <= state_d;
      copy_idx_q  <= copy_idx_d;
      re_arm_q    <= re_arm_d;
      sprite_en_q <= sprite_en_d;
      irq_en_q    <= irq_en_d;
      irq_flag_q  <= irq_flag_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      WORD_CTRL:  rd_word = {28'd0, (state_q != ST_IDLE), irq_flag_q, irq_en_q, sprite_en_q};
      WORD_FRAME: rd_word = 32'(frame_q);
`ifdef SPRITE_REGCTL_READBACK_EN
      WORD_SPR0_XY, WORD_SPR0_BMP0, WORD_SPR0_BMP1,
      WORD_SPR1_XY, WORD_SPR1_BMP0, WORD_SPR1_BMP1: rd_word = shadow_q[sh_idx];
`endif
      default:    rd_word = '0;
    endcase
  end

  assign data_ready = rst_n && (rd_req || (wr_req && !wr_stall));
  assign data_out   = (rst_n && rd_req) ? rd_word : '0;

  assign sprite_en      = sprite_en_q;
  assign user_interrupt = irq_flag_q;
  assign spr0_x   = live_q[0][9:0];
  assign spr0_y   = live_q[0][25:16];
  assign spr0_bmp = {live_q[2], live_q[1]};
  assign spr1_x   = live_q[3][9:0];
  assign spr1_y   = live_q[3][25:16];
  assign spr1_bmp = {live_q[5], live_q[4]};

  logic unused_bits;
  assign unused_bits = ^{address[1:0], live_q[0][31:26], live_q[0][15:10],
                         live_q[3][31:26], live_q[3][15:10]};

endmodule

// File: tb/tb_tqvp_sprite_regctl.sv
// Self-checking bench for tqvp_sprite_regctl: directed scenarios plus randomized
// shadow writes checked against a word-level model of the register map.
module tb_tqvp_sprite_regctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        vblank_start;
  logic        sprite_en;
  logic [9:0]  spr0_x, spr0_y, spr1_x, spr1_y;
  logic [63:0] spr0_bmp, spr1_bmp;
  logic        user_interrupt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the programmer-visible state, indexed by register word number.
  logic [31:0] m_shadow [1:6];
  logic [31:0] m_live   [1:6];
  logic        m_sprite_en, m_irq_en, m_flag, m_armed;
  int          m_frame;

  tqvp_sprite_regctl dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .vblank_start(vblank_start), .sprite_en(sprite_en),
    .spr0_x(spr0_x), .spr0_y(spr0_y), .spr1_x(spr1_x), .spr1_y(spr1_y),
    .spr0_bmp(spr0_bmp), .spr1_bmp(spr1_bmp), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] live_word(input int k);
    case (k)
      1: return {6'd0, spr0_y, 6'd0, spr0_x};
      2: return spr0_bmp[31:0];
      3: return spr0_bmp[63:32];
      4: return {6'd0, spr1_y, 6'd0, spr1_x};
      5: return spr1_bmp[31:0];
      6: return spr1_bmp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 1; k <= 6; k++) begin m_shadow[k] = 32'd0; m_live[k] = 32'd0; end
    m_sprite_en = 1'b0; m_irq_en = 1'b0; m_flag = 1'b0; m_armed = 1'b0; m_frame = 0;
  endfunction

  function automatic void model_write(input logic [3:0] w, input logic [31:0] d, input logic [1:0] wn);
    logic [31:0] mask;
    if (wn == 2'b11) return;
    mask = (wn == 2'b00) ? 32'h0000_00FF : (wn == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    if (w == 4'd0) begin
      m_sprite_en = d[0];
      m_irq_en    = d[1];
      if (d[2]) m_flag = 1'b0;
      if (d[3]) m_armed = 1'b1;
    end else if (w >= 4'd1 && w <= 4'd6) begin
      m_shadow[w] = (m_shadow[w] & ~mask) | (d & mask);
      if (w == 4'd1 || w == 4'd4) m_shadow[w] = m_shadow[w] & 32'h03FF_03FF;
    end
  endfunction

  function automatic void model_vblank();
    m_frame = (m_frame + 1) % 65536;
    if (m_irq_en) m_flag = 1'b1;
    if (m_armed) begin
      for (int k = 1; k <= 6; k++) m_live[k] = m_shadow[k];
      m_armed = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_ctrl();
    return {28'd0, m_armed, m_flag, m_irq_en, m_sprite_en};
  endfunction

  task automatic bus_write(input logic [3:0] w, input logic [31:0] d, input logic [1:0] wn, output int stalls);
    stalls = 0;
    @(negedge clk);
    address = {w, 2'b00}; data_in = d; data_write_n = wn;
    #1;
    while (data_ready !== 1'b1 && stalls < 20) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= 20) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL write_timeout word=%0d data_ready=%b required 1", w, data_ready);
    end
    @(posedge clk); #1;
    data_write_n = 2'b11;
    model_write(w, d, wn);
  endtask

  task automatic bus_read(input logic [3:0] w, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    address = {w, 2'b00}; data_read_n = 2'b10;
    #1;
    d = data_out; rdy = data_ready;
    data_read_n = 2'b11;
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank_start = 1'b1;
    @(posedge clk); #1; vblank_start = 1'b0;
    model_vblank();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address = 6'd0; data_in = 32'd0; data_write_n = 2'b11;
    data_read_n = 2'b10; vblank_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready got=%b exp=0", data_ready); end
    n_cmp++; if (data_out !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_data_out got=%h exp=0", data_out); end
    data_read_n = 2'b11;
    @(negedge clk); rst_n = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (live_word(k) !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_live%0d got=%h exp=0", k, live_word(k)); end
    end
    n_cmp++; if ({sprite_en, user_interrupt} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_en_irq got=%b exp=00", {sprite_en, user_interrupt}); end
    begin
      logic [31:0] d; logic r;
      bus_read(4'd0, d, r);
      n_cmp++; if (d !== 32'd0 || r !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ctrl got=%h/%b exp=0/1", d, r); end
      bus_read(4'd7, d, r);
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_frame got=%h exp=0", d); end
    end
  endtask

  task automatic test_no_commit();
    int s; logic [31:0] d; logic r;
    bus_write(4'd1, 32'h0064_0032, 2'b10, s);
    vblank_pulse();
    repeat (7) @(posedge clk); #1;
    n_cmp++; if (spr0_x !== 10'd0) begin n_bad++; $display("[TB] FAIL nocommit_x got=%h exp=0", spr0_x); end
    bus_read(4'd1, d, r);
`ifdef SPRITE_REGCTL_READBACK_EN
    n_cmp++; if (d !== 32'h0064_0032) begin n_bad++; $display("[TB] FAIL nocommit_readback got=%h exp=00640032", d); end
`else
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL nocommit_readback got=%h exp=0", d); end
`endif
    bus_read(4'd7, d, r);
    n_cmp++; if (d !== 32'(m_frame)) begin n_bad++; $display("[TB] FAIL nocommit_frame got=%h exp=%h", d, 32'(m_frame)); end
  endtask

  task automatic test_commit_latency();
    int s; logic [31:0] d; logic r;
    logic [31:0] old_live [1:6];
    logic [31:0] snap [1:6];
    for (int k = 2; k <= 6; k++) bus_write(4'(k), $urandom | 32'h1, 2'b10, s);
    bus_write(4'd0, 32'h9, 2'b10, s);
    n_cmp++; if (sprite_en !== 1'b1) begin n_bad++; $display("[TB] FAIL latency_sprite_en got=%b exp=1", sprite_en); end
    bus_read(4'd0, d, r);
    n_cmp++; if (d !== 32'h9) begin n_bad++; $display("[TB] FAIL latency_ctrl_armed got=%h exp=9", d); end
    for (int k = 1; k <= 6; k++) begin old_live[k] = m_live[k]; snap[k] = m_shadow[k]; end
    @(negedge clk); vblank_start = 1'b1;
    @(posedge clk); #1; vblank_start = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      for (int k = 1; k <= 6; k++) begin
        n_cmp++;
        if (live_word(k) !== ((k <= e) ? snap[k] : old_live[k])) begin
          n_bad++; $display("[TB] FAIL latency_edge%0d_word%0d got=%h exp=%h", e, k, live_word(k), (k <= e) ? snap[k] : old_live[k]);
        end
      end
    end
    model_vblank();
    n_cmp++; if (spr0_x !== 10'd50 || spr0_y !== 10'd100) begin n_bad++; $display("[TB] FAIL latency_xy got=%0d,%0d exp=50,100", spr0_x, spr0_y); end
    bus_read(4'd0, d, r);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("[TB] FAIL latency_ctrl_done got=%h exp=1", d); end
  endtask

  task automatic test_stall();
    int s; logic [31:0] a, b, d; logic r;
    a = $urandom; b = ~a;
    bus_write(4'd6, a, 2'b10, s);
    bus_write(4'd0, 32'h9, 2'b10, s);
    vblank_pulse();
    bus_write(4'd6, b, 2'b10, s);
    n_cmp++; if (s !== 6) begin n_bad++; $display("[TB] FAIL stall_cycles got=%0d exp=6", s); end
    n_cmp++; if (spr1_bmp[63:32] !== a) begin n_bad++; $display("[TB] FAIL stall_live got=%h exp=%h", spr1_bmp[63:32], a); end
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (live_word(k) !== m_live[k]) begin n_bad++; $display("[TB] FAIL stall_live%0d got=%h exp=%h", k, live_word(k), m_live[k]); end
    end
    bus_read(4'd6, d, r);
`ifdef SPRITE_REGCTL_READBACK_EN
    n_cmp++; if (d !== b) begin n_bad++; $display("[TB] FAIL stall_shadow got=%h exp=%h", d, b); end
`else
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL stall_shadow got=%h exp=0", d); end
`endif
  endtask

  task automatic test_irq();
    int s; logic r;
    bus_write(4'd0, 32'h2, 2'b10, s);
    n_cmp++; if (user_interrupt !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_idle got=%b exp=0", user_interrupt); end
    @(negedge clk);
    vblank_start = 1'b1; address = 6'd0; data_in = 32'h6; data_write_n = 2'b10;
    #1; r = data_ready;
    @(posedge clk); #1;
    vblank_start = 1'b0; data_write_n = 2'b11;
    model_write(4'd0, 32'h6, 2'b10);
    model_vblank();
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_ctrl_ready got=%b exp=1", r); end
    n_cmp++; if (user_interrupt !== 1'b1 || m_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_set_wins got=%b exp=1", user_interrupt); end
    bus_write(4'd0, 32'h6, 2'b10, s);
    n_cmp++; if (user_interrupt !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_clear got=%b exp=0", user_interrupt); end
    vblank_pulse();
    n_cmp++; if (user_interrupt !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_vblank_set got=%b exp=1", user_interrupt); end
    bus_write(4'd0, 32'h0, 2'b00, s);
    n_cmp++; if (user_interrupt !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_hold got=%b exp=1", user_interrupt); end
    bus_write(4'd0, 32'h4, 2'b00, s);
    vblank_pulse();
    n_cmp++; if (user_interrupt !== m_flag || m_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_disabled got=%b exp=0", user_interrupt); end
  endtask

  task automatic test_rearm();
    int s; logic [31:0] d; logic r;
    for (int k = 1; k <= 6; k++) bus_write(4'(k), $urandom, 2'b10, s);
    bus_write(4'd0, 32'h8, 2'b10, s);
    vblank_pulse();
    bus_write(4'd0, 32'h8, 2'b10, s);
    n_cmp++; if (s !== 0) begin n_bad++; $display("[TB] FAIL rearm_ctrl_stall got=%0d exp=0", s); end
    repeat (6) @(posedge clk); #1;
    bus_read(4'd0, d, r);
    n_cmp++; if (d !== exp_ctrl() || d[3] !== 1'b1) begin n_bad++; $display("[TB] FAIL rearm_ctrl got=%h exp=%h", d, exp_ctrl()); end
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (live_word(k) !== m_live[k]) begin n_bad++; $display("[TB] FAIL rearm_first%0d got=%h exp=%h", k, live_word(k), m_live[k]); end
    end
    bus_write(4'd2, $urandom, 2'b10, s);
    vblank_pulse();
    repeat (6) @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (live_word(k) !== m_live[k]) begin n_bad++; $display("[TB] FAIL rearm_second%0d got=%h exp=%h", k, live_word(k), m_live[k]); end
    end
    bus_read(4'd0, d, r);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("[TB] FAIL rearm_ctrl_idle got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_copy();
    int s; logic [31:0] d; logic r;
    for (int k = 1; k <= 6; k++) bus_write(4'(k), $urandom | 32'h0001_0001, 2'b10, s);
    bus_write(4'd0, 32'hB, 2'b10, s);
    vblank_pulse();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (live_word(2) !== m_shadow[2]) begin n_bad++; $display("[TB] FAIL midcopy_partial got=%h exp=%h", live_word(2), m_shadow[2]); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      n_cmp++; if (live_word(k) !== 32'd0) begin n_bad++; $display("[TB] FAIL midcopy_live%0d got=%h exp=0", k, live_word(k)); end
    end
    n_cmp++; if ({sprite_en, user_interrupt} !== 2'b00) begin n_bad++; $display("[TB] FAIL midcopy_en_irq got=%b exp=00", {sprite_en, user_interrupt}); end
    @(negedge clk); rst_n = 1'b1;
    bus_read(4'd0, d, r);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL midcopy_ctrl got=%h exp=0", d); end
    bus_read(4'd7, d, r);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL midcopy_frame got=%h exp=0", d); end
  endtask

  task automatic test_random();
    int s; logic [31:0] d; logic r; logic [3:0] w;
    for (int round = 0; round < 20; round++) begin
      for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
        bus_write(4'($urandom_range(1, 6)), $urandom, 2'($urandom_range(0, 2)), s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("[TB] FAIL rand_stall got=%0d exp=0", s); end
      end
      w = 4'($urandom_range(8, 15));
      bus_write(w, $urandom, 2'b10, s);
      bus_read(w, d, r);
      n_cmp++; if (d !== 32'd0 || r !== 1'b1) begin n_bad++; $display("[TB] FAIL rand_reserved%0d got=%h/%b exp=0/1", w, d, r); end
      w = 4'($urandom_range(1, 6));
      bus_read(w, d, r);
`ifdef SPRITE_REGCTL_READBACK_EN
      n_cmp++; if (d !== m_shadow[w]) begin n_bad++; $display("[TB] FAIL rand_readback%0d got=%h exp=%h", w, d, m_shadow[w]); end
`else
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("[TB] FAIL rand_readback%0d got=%h exp=0", w, d); end
`endif
      bus_write(4'd0, 32'h8 | 32'($urandom_range(0, 3)), 2'b10, s);
      bus_read(4'd0, d, r);
      n_cmp++; if (d !== exp_ctrl()) begin n_bad++; $display("[TB] FAIL rand_ctrl got=%h exp=%h", d, exp_ctrl()); end
      vblank_pulse();
      repeat (6) @(posedge clk); #1;
      for (int k = 1; k <= 6; k++) begin
        n_cmp++; if (live_word(k) !== m_live[k]) begin n_bad++; $display("[TB] FAIL rand_live%0d got=%h exp=%h", k, live_word(k), m_live[k]); end
      end
      n_cmp++; if (sprite_en !== m_sprite_en || user_interrupt !== m_flag) begin n_bad++; $display("[TB] FAIL rand_en_irq got=%b%b exp=%b%b", sprite_en, user_interrupt, m_sprite_en, m_flag); end
      bus_read(4'd7, d, r);
      n_cmp++; if (d !== 32'(m_frame)) begin n_bad++; $display("[TB] FAIL rand_frame got=%h exp=%h", d, 32'(m_frame)); end
    end
  endtask

  task automatic test_frame_wrap();
    int s, n; logic [31:0] d; logic r;
    n = 65536 - m_frame;
    @(negedge clk); vblank_start = 1'b1;
    repeat (n - 1) @(posedge clk);
    #1; vblank_start = 1'b0;
    m_frame = (m_frame + n - 1) % 65536;
    if (m_irq_en) m_flag = 1'b1;
    bus_read(4'd7, d, r);
    n_cmp++; if (d !== 32'h0000_FFFF) begin n_bad++; $display("[TB] FAIL frame_max got=%h exp=0000ffff", d); end
    vblank_pulse();
    bus_read(4'd7, d, r);
    n_cmp++; if (d !== 32'd0 || m_frame != 0) begin n_bad++; $display("[TB] FAIL frame_wrap got=%h exp=0", d); end
    bus_write(4'd1, 32'h0064_0032, 2'b10, s);
    bus_write(4'd1, 32'hABCD_12FF, 2'b00, s);
    bus_write(4'd0, 32'h9, 2'b10, s);
    vblank_pulse();
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (spr0_x !== 10'h0FF || spr0_y !== 10'd100) begin n_bad++; $display("[TB] FAIL byte_write_xy got=%h,%h exp=0ff,064", spr0_x, spr0_y); end
    n_cmp++; if (live_word(1) !== m_live[1]) begin n_bad++; $display("[TB] FAIL byte_write_model got=%h exp=%h", live_word(1), m_live[1]); end
  endtask

  initial begin
    test_reset();
    test_no_commit();
    test_commit_latency();
    test_stall();
    test_irq();
    test_rearm();
    test_reset_mid_copy();
    test_random();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
